// File: rtl/mant_mul_arb.sv
// Two-requester round-robin front end for the shared pipelined mantissa
// multiplier; products return to their issuer in issue order.
module mant_mul_arb #(
  parameter int MANT_W  = 23,
  parameter int MUL_LAT = 2,
  localparam int PW = 2*MANT_W+2,
  localparam int CW = $clog2(MUL_LAT+1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              hold,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic              req0_a_is_sub,
  input  logic              req0_b_is_sub,
  input  logic [MANT_W-1:0] req0_a_mant,
  input  logic [MANT_W-1:0] req0_b_mant,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic              req1_a_is_sub,
  input  logic              req1_b_is_sub,
  input  logic [MANT_W-1:0] req1_a_mant,
  input  logic [MANT_W-1:0] req1_b_mant,
  output logic              res0_valid,
  output logic [PW-1:0]     res0_mant,
  output logic              res1_valid,
  output logic [PW-1:0]     res1_mant,
  output logic [CW-1:0]     inflight
);

  logic [MUL_LAT-1:0] vld;
  logic [MUL_LAT-1:0] tag;
  logic [PW-1:0]      prod [MUL_LAT];
  logic               last_grant;
  logic               g0;
  logic               g1;
  logic               hs;
  logic               sel;
  logic               res_any;
  logic [MANT_W:0]    a;
  logic [MANT_W:0]    b;
  logic [PW-1:0]      prod_in;
  logic [CW-1:0]      cnt;

  // last_grant==1 means requester 1 went last, so 0 wins a tie
  always_comb begin
    g0 = req0_valid & (~req1_valid | last_grant);
    g1 = req1_valid & (~req0_valid | ~last_grant);
    req0_ready = g0 & ~hold;
    req1_ready = g1 & ~hold;
    hs  = req0_ready | req1_ready;
    sel = req1_ready;
    if (sel) begin
      a = {~req1_a_is_sub, req1_a_mant};
      b = {~req1_b_is_sub, req1_b_mant};
    end else begin
      a = {~req0_a_is_sub, req0_a_mant};
      b = {~req0_b_is_sub, req0_b_mant};
    end
    prod_in = PW'(a) * PW'(b);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld        <= '0;
      tag        <= '0;
      last_grant <= 1'b1;
      cnt        <= '0;
      for (int i = 0; i < MUL_LAT; i++) prod[i] <= '0;
    end else if (!hold) begin
      vld[0]  <= hs;
      tag[0]  <= sel;
      prod[0] <= prod_in;
      for (int i = 1; i < MUL_LAT; i++) begin
        vld[i]  <= vld[i-1];
        tag[i]  <= tag[i-1];
        prod[i] <= prod[i-1];
      end
      if (hs) last_grant <= sel;
      cnt <= cnt + CW'(hs) - CW'(res_any);
    end
  end

  assign res_any    = vld[MUL_LAT-1] & ~hold;
  assign res0_valid = res_any & ~tag[MUL_LAT-1];
  assign res1_valid = res_any & tag[MUL_LAT-1];
  assign res0_mant  = prod[MUL_LAT-1];
  assign res1_mant  = prod[MUL_LAT-1];
  assign inflight   = cnt;

endmodule

// File: tb/tb_mant_mul_arb.sv
// Directed bench for mant_mul_arb: stimulus pushes expected products,
// a negedge monitor pops and compares them as results emerge.
module tb_mant_mul_arb;
  localparam int W  = 23;
  localparam int L  = 2;
  localparam int PW = 2*W+2;
  localparam int CW = $clog2(L+1);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          hold = 1'b0;
  logic          req0_valid = 1'b0;
  logic          req0_ready;
  logic          req0_a_is_sub = 1'b0;
  logic          req0_b_is_sub = 1'b0;
  logic [W-1:0]  req0_a_mant = '0;
  logic [W-1:0]  req0_b_mant = '0;
  logic          req1_valid = 1'b0;
  logic          req1_ready;
  logic          req1_a_is_sub = 1'b0;
  logic          req1_b_is_sub = 1'b0;
  logic [W-1:0]  req1_a_mant = '0;
  logic [W-1:0]  req1_b_mant = '0;
  logic          res0_valid;
  logic [PW-1:0] res0_mant;
  logic          res1_valid;
  logic [PW-1:0] res1_mant;
  logic [CW-1:0] inflight;

  mant_mul_arb #(.MANT_W(W), .MUL_LAT(L)) dut (
    .clk(clk), .rst(rst), .hold(hold),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a_is_sub(req0_a_is_sub), .req0_b_is_sub(req0_b_is_sub),
    .req0_a_mant(req0_a_mant), .req0_b_mant(req0_b_mant),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a_is_sub(req1_a_is_sub), .req1_b_is_sub(req1_b_is_sub),
    .req1_a_mant(req1_a_mant), .req1_b_mant(req1_b_mant),
    .res0_valid(res0_valid), .res0_mant(res0_mant),
    .res1_valid(res1_valid), .res1_mant(res1_mant),
    .inflight(inflight)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit           as;
    logic [W-1:0] am;
    bit           bs;
    logic [W-1:0] bm;
    logic [PW-1:0] p;
  } vec_t;

  typedef struct {
    bit            tag;
    logic [PW-1:0] p;
  } exp_t;

  vec_t tbl [8];
  exp_t exp_q [$];
  vec_t cur0;
  vec_t cur1;
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic drive(int r, bit v, int idx);
    if (r == 0) begin
      cur0 = tbl[idx];
      req0_valid = v;
      req0_a_is_sub = cur0.as;
      req0_a_mant = cur0.am;
      req0_b_is_sub = cur0.bs;
      req0_b_mant = cur0.bm;
    end else begin
      cur1 = tbl[idx];
      req1_valid = v;
      req1_a_is_sub = cur1.as;
      req1_a_mant = cur1.am;
      req1_b_is_sub = cur1.bs;
      req1_b_mant = cur1.bm;
    end
  endtask

  // called at a negedge: record the handshake the next posedge will take
  task automatic push_hs();
    exp_t e;
    if (req0_valid && req0_ready) begin
      e.tag = 1'b0;
      e.p = cur0.p;
      exp_q.push_back(e);
    end
    if (req1_valid && req1_ready) begin
      e.tag = 1'b1;
      e.p = cur1.p;
      exp_q.push_back(e);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 20; i++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk);
    end
    chk("drain_left", 64'(exp_q.size()), 64'd0);
    step();
  endtask

  task automatic rst_pulse();
    #2 rst = 1'b1;
    exp_q.delete();
    #2 rst = 1'b0;
    step();
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (res0_valid || res1_valid) begin
      chk("res_onehot", 64'(res0_valid & res1_valid), 64'd0);
      if (exp_q.size() == 0) begin
        chk("res_unexpected", 64'(res1_valid), 64'hdead);
      end else begin
        e = exp_q.pop_front();
        chk("res_tag", 64'(res1_valid), 64'(e.tag));
        chk("res_mant", 64'(res1_valid ? res1_mant : res0_mant), 64'(e.p));
      end
    end
  end

  initial begin
    tbl[0] = '{0, 23'h0,      0, 23'h0,  48'h400000000000};
    tbl[1] = '{0, 23'h7FFFFF, 0, 23'h7FFFFF, 48'hFFFFFE000001};
    tbl[2] = '{1, 23'h1,      0, 23'h0,  48'h000000800000};
    tbl[3] = '{0, 23'h1,      0, 23'h0,  48'h400000800000};
    tbl[4] = '{0, 23'h2,      0, 23'h0,  48'h400001000000};
    tbl[5] = '{1, 23'h3,      1, 23'h5,  48'h00000000000F};
    tbl[6] = '{1, 23'h7FFFFF, 1, 23'h2,  48'h000000FFFFFE};
    tbl[7] = '{0, 23'h0,      1, 23'h10, 48'h000008000000};

    #2;
    chk("rst_res0_valid", 64'(res0_valid), 64'd0);
    chk("rst_res1_valid", 64'(res1_valid), 64'd0);
    chk("rst_inflight", 64'(inflight), 64'd0);
    chk("rst_res0_mant", 64'(res0_mant), 64'd0);
    chk("rst_res1_mant", 64'(res1_mant), 64'd0);
    #10 rst = 1'b0;
    step();

    // single issue, latency and inflight
    drive(0, 1, 0);
    @(negedge clk);
    chk("t1_ready0", 64'(req0_ready), 64'd1);
    chk("t1_ready1", 64'(req1_ready), 64'd0);
    push_hs();
    step();
    req0_valid = 1'b0;
    @(negedge clk);
    chk("t1_inflight1", 64'(inflight), 64'd1);
    chk("t1_early", 64'(res0_valid), 64'd0);
    step();
    @(negedge clk);
    chk("t1_res0_valid", 64'(res0_valid), 64'd1);
    chk("t1_res1_valid", 64'(res1_valid), 64'd0);
    step();
    @(negedge clk);
    chk("t1_inflight0", 64'(inflight), 64'd0);
    drain();

    // max operands on requester 1, subnormal on requester 0
    drive(1, 1, 1);
    @(negedge clk);
    push_hs();
    step();
    req1_valid = 1'b0;
    drain();
    drive(0, 1, 2);
    @(negedge clk);
    push_hs();
    step();
    req0_valid = 1'b0;
    drain();

    // contention right after reset
    rst_pulse();
    for (int c = 0; c < 6; c++) begin
      drive(0, 1, c % 8);
      drive(1, 1, (c + 3) % 8);
      @(negedge clk);
      chk("cont_ready0", 64'(req0_ready), 64'(c % 2 == 0));
      chk("cont_ready1", 64'(req1_ready), 64'(c % 2 == 1));
      chk("cont_inflight", 64'(inflight), 64'(c < 2 ? c : 2));
      push_hs();
      step();
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    drain();

    // hold for 3 cycles when the first result is due
    drive(0, 1, 3);
    @(negedge clk);
    push_hs();
    step();
    req0_valid = 1'b0;
    drive(1, 1, 4);
    @(negedge clk);
    push_hs();
    step();
    req1_valid = 1'b0;
    hold = 1'b1;
    drive(0, 1, 5);
    for (int h = 0; h < 3; h++) begin
      @(negedge clk);
      chk("hold_res0", 64'(res0_valid), 64'd0);
      chk("hold_res1", 64'(res1_valid), 64'd0);
      chk("hold_ready0", 64'(req0_ready), 64'd0);
      chk("hold_inflight", 64'(inflight), 64'd2);
      step();
      req0_valid = 1'b0;
    end
    hold = 1'b0;
    @(negedge clk);
    chk("rel_res0", 64'(res0_valid), 64'd1);
    step();
    @(negedge clk);
    chk("rel_res1", 64'(res1_valid), 64'd1);
    step();
    @(negedge clk);
    chk("rel_done", 64'(res0_valid | res1_valid), 64'd0);
    drain();

    // async reset with two operations in flight
    drive(0, 1, 6);
    @(negedge clk);
    push_hs();
    step();
    req0_valid = 1'b0;
    drive(1, 1, 7);
    @(negedge clk);
    push_hs();
    step();
    req1_valid = 1'b0;
    #2 rst = 1'b1;
    exp_q.delete();
    #1;
    chk("ar_res0", 64'(res0_valid), 64'd0);
    chk("ar_res1", 64'(res1_valid), 64'd0);
    chk("ar_inflight", 64'(inflight), 64'd0);
    @(negedge clk);
    #2 rst = 1'b0;
    repeat (4) step();
    drive(0, 1, 0);
    drive(1, 1, 1);
    @(negedge clk);
    chk("ar_tie_ready0", 64'(req0_ready), 64'd1);
    chk("ar_tie_ready1", 64'(req1_ready), 64'd0);
    push_hs();
    step();
    @(negedge clk);
    chk("ar_next_ready1", 64'(req1_ready), 64'd1);
    push_hs();
    step();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    drain();
    repeat (3) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/mant_mul_arb.md
# mant_mul_arb

Round-robin arbiter and sequencer for the shared mantissa multiplier in the pipelined FP multiply unit. Two requesters (e.g. two FP-mul lanes) present `{is_sub, mant}` operand pairs with a valid/ready handshake. The block grants at most one per cycle, pushes the operands through an `MUL_LAT`-stage pipelined `(MANT_W+1)x(MANT_W+1)` unsigned product, and returns each `(2*MANT_W+2)`-bit product to the requester that issued it, in issue order. A global `hold` freezes the whole pipeline without losing or duplicating results.

## Interface
- `MANT_W`, 23, stored mantissa width; operands are `MANT_W+1` bits including the hidden bit.
- `MUL_LAT`, 2, pipeline depth in cycles from accept to result; legal range 1..8.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `hold`  in  1  freeze: no grants, no pipeline advance, `res*_valid` forced low.
- `req0_valid`  in  1  requester 0 has an operand pair.
- `req0_ready`  out  1  requester 0 accepted this cycle (combinational).
- `req0_a_is_sub`, `req0_b_is_sub`  in  1 each  operand subnormal flags; hidden bit = ~is_sub.
- `req0_a_mant`, `req0_b_mant`  in  `MANT_W` each  stored mantissas.
- `req1_*`  identical set for requester 1.
- `res0_valid`  out  1  product for requester 0 valid this cycle; no backpressure.
- `res0_mant`  out  `2*MANT_W+2`  product for requester 0.
- `res1_valid`, `res1_mant`  identical for requester 1.
- `inflight`  out  `$clog2(MUL_LAT+1)`  number of accepted operations not yet returned.

## Operation
- Operand formation: `a = {~a_is_sub, a_mant}` and `b = {~b_is_sub, b_mant}`, giving two `MANT_W+1`-bit unsigned operands. Product = `a*b`, full `2*MANT_W+2` bits, no truncation or rounding.
- Arbitration, evaluated when `hold`=0:
  - Only one requester valid → that requester is granted.
  - Both valid → the requester not granted most recently (`last_grant` pointer) is granted.
  - Neither valid → no grant.
- `reqN_ready` = grant to N & ~`hold`. Ready may depend on valid. A handshake is valid & ready at the rising edge.
- On a handshake: `last_grant` ← granted index. Stage 1 captures the operands, `vld`=1 and `tag`=index. Otherwise stage 1 captures `vld`=0 (a bubble).
- Each edge with `hold`=0: stage k+1 ← stage k for `vld`, `tag` and the partial/final product. The multiply may be split across stages freely, provided the final stage holds the exact product.
- Outputs:
  - `res0_valid` = `vld_L` & (`tag_L`==0) & ~`hold`.
  - `res1_valid` = `vld_L` & (`tag_L`==1) & ~`hold`.
  - Both `resN_mant` are driven from the final stage (shared bus). Their value is don't-care when the corresponding valid is low.
- `hold`=1: all stage registers and `last_grant` keep their values, both readies are 0, and both res valids are 0. On release, the held final-stage result is presented exactly once.
- `inflight`: +1 on a handshake, −1 when any `res*_valid` is high, unchanged when both occur in the same cycle. It never exceeds `MUL_LAT`.
- Results are returned strictly in issue order. No reordering or dropping is allowed.

## Timing
- Reset values (asynchronous, while `rst`=1):
  - All `vld` = 0; `last_grant` = 1, so requester 0 wins the first tie.
  - `inflight` = 0; stage data = 0; `res*_valid` = 0; `res*_mant` = 0.
- Latency with `hold`=0 throughout: accept at edge e → `res_valid` high during the cycle between edges e+L−1 and e+L, where L = `MUL_LAT`.
  - For L=1, the result is visible the cycle immediately after the accepting edge.
- Each asserted `hold` cycle adds exactly one cycle of latency to every in-flight operation.
- Throughput: one operation per cycle total. Under continuous dual requests, grants alternate 0,1,0,1…
- Reset mid-operation: all in-flight operations are discarded, no result is ever presented for them, and `inflight` returns to 0.
- The `hold` edge and a `req` arriving in the same cycle: no grant, because `hold` dominates.

## Test plan
- Reset then single issue: `req0` with a=`{is_sub=0, mant=0}` and b=`{0, 0}` at edge 0. Expect `res0_valid` in the cycle after edge 1 (L=2) with `res0_mant`=`1<<46`. `res1_valid` stays 0 and `inflight` goes 0→1→0.
- Max operands: both `is_sub`=0 and mant=all-ones (a=b=2^24−1). Expect `res_mant`=`0xFFFFFE000001` (48 bits).
- Subnormal path: `a_is_sub`=1 with mant=1, `b_is_sub`=0 with mant=0. Expect product = `1<<23`.
- Contention: both requesters valid for 6 consecutive cycles right after reset.
  - Grants go 0,1,0,1,0,1 and each ready is high only on its own turn.
  - Results arrive in the same alternating order, tags match, and `inflight` saturates at 2.
- Hold: issue at cycles 0 and 1, then raise `hold` for 3 cycles starting when the first result is due.
  - No `res_valid` during `hold` and no readies.
  - After release, both results appear exactly once, 3 cycles late.
- Async reset with 2 operations in flight: assert `rst` between edges.
  - `res*_valid` and `inflight` drop to 0 immediately and no result ever emerges.
  - After release, a tie grants requester 0 first.
